// File: rtl/hangman_pkg.sv
// Shared constants, letter codes and FSM state type for the letter-guess engine
// and the display datapath that reuses letter_match.
package hangman_pkg;

    localparam int LETTER_W = 5;
    localparam logic [LETTER_W-1:0] EMPTY_SLOT = 5'h1F;
    localparam int ALPHABET = 26;

    localparam logic [LETTER_W-1:0] L_A = 5'd0;
    localparam logic [LETTER_W-1:0] L_B = 5'd1;
    localparam logic [LETTER_W-1:0] L_C = 5'd2;
    localparam logic [LETTER_W-1:0] L_D = 5'd3;
    localparam logic [LETTER_W-1:0] L_E = 5'd4;
    localparam logic [LETTER_W-1:0] L_F = 5'd5;
    localparam logic [LETTER_W-1:0] L_G = 5'd6;
    localparam logic [LETTER_W-1:0] L_H = 5'd7;
    localparam logic [LETTER_W-1:0] L_I = 5'd8;
    localparam logic [LETTER_W-1:0] L_J = 5'd9;
    localparam logic [LETTER_W-1:0] L_K = 5'd10;
    localparam logic [LETTER_W-1:0] L_L = 5'd11;
    localparam logic [LETTER_W-1:0] L_M = 5'd12;
    localparam logic [LETTER_W-1:0] L_N = 5'd13;
    localparam logic [LETTER_W-1:0] L_O = 5'd14;
    localparam logic [LETTER_W-1:0] L_P = 5'd15;
    localparam logic [LETTER_W-1:0] L_Q = 5'd16;
    localparam logic [LETTER_W-1:0] L_R = 5'd17;
    localparam logic [LETTER_W-1:0] L_S = 5'd18;
    localparam logic [LETTER_W-1:0] L_T = 5'd19;
    localparam logic [LETTER_W-1:0] L_U = 5'd20;
    localparam logic [LETTER_W-1:0] L_V = 5'd21;
    localparam logic [LETTER_W-1:0] L_W = 5'd22;
    localparam logic [LETTER_W-1:0] L_X = 5'd23;
    localparam logic [LETTER_W-1:0] L_Y = 5'd24;
    localparam logic [LETTER_W-1:0] L_Z = 5'd25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_GO,
        S_HELD,
        S_EVAL,
        S_WON,
        S_LOST
    } state_t;

    // True for codes A..Z; codes 26..31 (including EMPTY_SLOT) are not letters.
    function automatic logic is_letter(input logic [LETTER_W-1:0] code);
        return int'(code) < ALPHABET;
    endfunction

endpackage

// File: rtl/letter_match.sv
// Parallel compare of one letter code against every slot of a packed word.
module letter_match
    import hangman_pkg::*;
#(
    parameter int WORD_LEN = 5
) (
    input  logic [LETTER_W-1:0]          i_guess,
    input  logic [LETTER_W*WORD_LEN-1:0] i_word,
    output logic [WORD_LEN-1:0]          o_hit_vec
);

    // One equality comparator per slot; an invalid code such as 5'h1F will
    // match empty slots, so callers must qualify the result with is_letter().
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        o_hit_vec = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            o_hit_vec[i] = (i_word[LETTER_W*i +: LETTER_W] == i_guess);
        end
    end

endmodule

// File: rtl/hangman_guess_engine.sv
// Letter-guess game controller: latches a target word, evaluates one guess per
// go press/release, and tracks revealed slots, used letters, misses and status.
module hangman_guess_engine
    import hangman_pkg::*;
#(
    parameter int WORD_LEN   = 5,
    parameter int MAX_MISSES = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_word,
    input  logic [LETTER_W*WORD_LEN-1:0] word_in,
    input  logic                         go,
    input  logic [LETTER_W-1:0]          guess,
    output logic [WORD_LEN-1:0]          revealed,
    output logic [ALPHABET-1:0]          used_mask,
    output logic [3:0]                   misses,
    output logic                         result_valid,
    output logic                         last_hit,
    output logic                         last_repeat,
    output logic                         last_invalid,
    output logic                         won,
    output logic                         lost,
    output logic                         busy
);

    localparam logic [3:0] MAX_MISS_C = 4'(MAX_MISSES);

    state_t                         r_state;
    logic [LETTER_W*WORD_LEN-1:0]   r_word;
    logic [LETTER_W-1:0]            r_guess;
    logic [WORD_LEN-1:0]            r_revealed;
    logic [ALPHABET-1:0]            r_used_mask;
    logic [3:0]                     r_misses;
    logic                           r_result_valid;
    logic                           r_last_hit;
    logic                           r_last_repeat;
    logic                           r_last_invalid;
    logic                           r_won;
    logic                           r_lost;
    logic                           r_busy;

    logic [WORD_LEN-1:0]            w_load_empty;
    logic [WORD_LEN-1:0]            w_hit_vec;
    logic                           w_valid;
    logic                           w_repeat;
    logic                           w_fresh;
    logic                           w_any_hit;
    logic                           w_miss;
    logic [WORD_LEN-1:0]            w_new_revealed;
    logic [ALPHABET-1:0]            w_new_used;
    logic [3:0]                     w_new_misses;
    logic                           w_new_won;
    logic                           w_new_lost;

    letter_match #(
        .WORD_LEN (WORD_LEN)
    ) u_letter_match (
        .i_guess   (r_guess),
        .i_word    (r_word),
        .o_hit_vec (w_hit_vec)
    );

    // Slots of the incoming word that are padding; they start out revealed.
    always_comb begin
        w_load_empty = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            w_load_empty[i] = (word_in[LETTER_W*i +: LETTER_W] == EMPTY_SLOT);
        end
    end

    // Outcome of evaluating the latched guess against the current game state.
    always_comb begin
        w_valid        = is_letter(r_guess);
        w_repeat       = w_valid && r_used_mask[r_guess];
        w_fresh        = w_valid && !w_repeat;
        w_any_hit      = |w_hit_vec;
        w_miss         = w_fresh && !w_any_hit;
        w_new_revealed = r_revealed;
        w_new_used     = r_used_mask;
        w_new_misses   = r_misses;
        if (w_fresh) begin
            w_new_revealed = r_revealed | w_hit_vec;
            w_new_used     = r_used_mask | (ALPHABET'(1) << r_guess);
        end
        if (w_miss && (r_misses < MAX_MISS_C)) begin
            w_new_misses = r_misses + 4'd1;
        end
        w_new_won  = &w_new_revealed;
        w_new_lost = !w_new_won && (w_new_misses == MAX_MISS_C);
    end

    // Game FSM with all outputs registered; load_word overrides every state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            // NOTE: the word store is a handful of flops, not a RAM, so it is
            // reset too; a reset genuinely forgets the current word.
            r_word         <= '0;
            r_guess        <= '0;
            r_revealed     <= '0;
            r_used_mask    <= '0;
            r_misses       <= '0;
            r_result_valid <= 1'b0;
            r_last_hit     <= 1'b0;
            r_last_repeat  <= 1'b0;
            r_last_invalid <= 1'b0;
            r_won          <= 1'b0;
            r_lost         <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (load_word) begin
                r_word         <= word_in;
                r_revealed     <= w_load_empty;
                r_used_mask    <= '0;
                r_misses       <= '0;
                r_last_hit     <= 1'b0;
                r_last_repeat  <= 1'b0;
                r_last_invalid <= 1'b0;
                r_lost         <= 1'b0;
                r_busy         <= 1'b0;
                r_won          <= &w_load_empty;
                r_state        <= (&w_load_empty) ? S_WON : S_WAIT_GO;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_WAIT_GO: begin
                        if (go) begin
                            r_guess <= guess;
                            r_busy  <= 1'b1;
                            r_state <= S_HELD;
                        end
                    end
                    S_HELD: begin
                        if (!go) begin
                            r_state <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        r_revealed     <= w_new_revealed;
                        r_used_mask    <= w_new_used;
                        r_misses       <= w_new_misses;
                        r_last_invalid <= !w_valid;
                        r_last_repeat  <= w_repeat;
                        r_last_hit     <= w_fresh && w_any_hit;
                        r_won          <= w_new_won;
                        r_lost         <= w_new_lost;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        if (w_new_won) begin
                            r_state <= S_WON;
                        end else if (w_new_lost) begin
                            r_state <= S_LOST;
                        end else begin
                            r_state <= S_WAIT_GO;
                        end
                    end
                    S_WON, S_LOST: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign revealed     = r_revealed;
    assign used_mask    = r_used_mask;
    assign misses       = r_misses;
    assign result_valid = r_result_valid;
    assign last_hit     = r_last_hit;
    assign last_repeat  = r_last_repeat;
    assign last_invalid = r_last_invalid;
    assign won          = r_won;
    assign lost         = r_lost;
    assign busy         = r_busy;

endmodule

// File: tb/tb_hangman_guess_engine.sv
// Self-checking bench: directed vector table, two hand-written corner sequences,
// then randomized games compared against a rule-level reference model.
module tb_hangman_guess_engine;
    import hangman_pkg::*;

    localparam int WORD_LEN   = 5;
    localparam int MAX_MISSES = 6;
    localparam int WW         = LETTER_W * WORD_LEN;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_HIT  = 3'b100;
    localparam logic [2:0] F_REP  = 3'b010;
    localparam logic [2:0] F_INV  = 3'b001;

    // S,T,A,Y with slot 4 empty; E,E,L,L with slot 4 empty; all slots empty.
    localparam logic [WW-1:0] W_STAY = {5'h1F, 5'd24, 5'd0, 5'd19, 5'd18};
    localparam logic [WW-1:0] W_EELL = {5'h1F, 5'd11, 5'd11, 5'd4, 5'd4};
    localparam logic [WW-1:0] W_NONE = {5{5'h1F}};

    logic                clk = 1'b0;
    logic                reset;
    logic                load_word;
    logic [WW-1:0]       word_in;
    logic                go;
    logic [4:0]          guess;
    logic [WORD_LEN-1:0] revealed;
    logic [25:0]         used_mask;
    logic [3:0]          misses;
    logic                result_valid;
    logic                last_hit;
    logic                last_repeat;
    logic                last_invalid;
    logic                won;
    logic                lost;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hangman_guess_engine #(
        .WORD_LEN   (WORD_LEN),
        .MAX_MISSES (MAX_MISSES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_word    (load_word),
        .word_in      (word_in),
        .go           (go),
        .guess        (guess),
        .revealed     (revealed),
        .used_mask    (used_mask),
        .misses       (misses),
        .result_valid (result_valid),
        .last_hit     (last_hit),
        .last_repeat  (last_repeat),
        .last_invalid (last_invalid),
        .won          (won),
        .lost         (lost),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string p, input logic [WORD_LEN-1:0] e_rev,
                              input logic [25:0] e_used, input logic [3:0] e_mis,
                              input logic [2:0] e_flg, input bit e_won, input bit e_lost);
        check({p, ".revealed"},  64'(revealed),  64'(e_rev));
        check({p, ".used_mask"}, 64'(used_mask), 64'(e_used));
        check({p, ".misses"},    64'(misses),    64'(e_mis));
        check({p, ".flags"},     64'({last_hit, last_repeat, last_invalid}), 64'(e_flg));
        check({p, ".won"},       64'(won),       64'(e_won));
        check({p, ".lost"},      64'(lost),      64'(e_lost));
    endtask

    // ---------------- reference model (rule level) ----------------
    int  m_word [WORD_LEN];
    bit  m_rev  [WORD_LEN];
    bit  m_used [ALPHABET];
    int  m_mis;
    bit  m_hit, m_rep, m_inv, m_won, m_lost;

    function automatic void model_load(input logic [WW-1:0] w);
        m_won = 1'b1;
        for (int i = 0; i < WORD_LEN; i++) begin
            m_word[i] = int'(w[LETTER_W*i +: LETTER_W]);
            m_rev[i]  = (m_word[i] == 31);
            if (!m_rev[i]) m_won = 1'b0;
        end
        for (int n = 0; n < ALPHABET; n++) m_used[n] = 1'b0;
        m_mis = 0; m_hit = 0; m_rep = 0; m_inv = 0; m_lost = 0;
    endfunction

    // Returns 1 when the press is expected to produce a result.
    function automatic bit model_guess(input int g);
        int found;
        if (m_won || m_lost) return 1'b0;
        m_hit = 0; m_rep = 0; m_inv = 0;
        if (g >= ALPHABET) begin
            m_inv = 1;
        end else if (m_used[g]) begin
            m_rep = 1;
        end else begin
            m_used[g] = 1;
            found = 0;
            for (int i = 0; i < WORD_LEN; i++) begin
                if (m_word[i] == g) begin
                    m_rev[i] = 1;
                    found++;
                end
            end
            if (found > 0) m_hit = 1;
            else if (m_mis < MAX_MISSES) m_mis++;
        end
        m_won = 1'b1;
        for (int i = 0; i < WORD_LEN; i++) if (!m_rev[i]) m_won = 1'b0;
        m_lost = !m_won && (m_mis == MAX_MISSES);
        return 1'b1;
    endfunction

    function automatic logic [WORD_LEN-1:0] model_rev();
        logic [WORD_LEN-1:0] v = '0;
        for (int i = 0; i < WORD_LEN; i++) v[i] = m_rev[i];
        return v;
    endfunction

    function automatic logic [25:0] model_used();
        logic [25:0] v = '0;
        for (int n = 0; n < ALPHABET; n++) v[n] = m_used[n];
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [25:0] U(input int n);
        return 26'd1 << n;
    endfunction

    task automatic do_load(input logic [WW-1:0] w);
        @(negedge clk);
        load_word = 1'b1;
        word_in   = w;
        @(negedge clk);
        load_word = 1'b0;
    endtask

    // Press go with guess g, switch the guess input to alt while held, release
    // after 'hold' cycles, then watch six cycles for result_valid.
    task automatic do_press(input logic [4:0] g, input logic [4:0] alt, input int hold,
                            output int n_rv, output int lat, output logic busy_s);
        @(negedge clk);
        go    = 1'b1;
        guess = g;
        @(negedge clk);
        busy_s = busy;
        guess  = alt;
        repeat (hold - 1) @(negedge clk);
        go   = 1'b0;
        n_rv = 0;
        lat  = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (result_valid) begin
                if (n_rv == 0) lat = k;
                n_rv++;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit                  is_load;
        logic [WW-1:0]       word;
        logic [4:0]          g;
        logic [4:0]          alt;
        int                  hold;
        bit                  exp_rv;
        logic [WORD_LEN-1:0] rev;
        logic [25:0]         used;
        logic [3:0]          mis;
        logic [2:0]          flg;
        bit                  won;
        bit                  lost;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t ld(input logic [WW-1:0] w, input logic [WORD_LEN-1:0] rev, input bit wn);
        vec_t v;
        v.is_load = 1; v.word = w; v.g = '0; v.alt = '0; v.hold = 0; v.exp_rv = 0;
        v.rev = rev; v.used = '0; v.mis = '0; v.flg = F_NONE; v.won = wn; v.lost = 0;
        return v;
    endfunction

    function automatic vec_t pr(input logic [4:0] g, input logic [4:0] alt, input int hold,
                                input bit rv, input logic [WORD_LEN-1:0] rev, input logic [25:0] used,
                                input logic [3:0] mis, input logic [2:0] flg, input bit wn, input bit ls);
        vec_t v;
        v.is_load = 0; v.word = '0; v.g = g; v.alt = alt; v.hold = hold; v.exp_rv = rv;
        v.rev = rev; v.used = used; v.mis = mis; v.flg = flg; v.won = wn; v.lost = ls;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n_rv;
        int          lat;
        logic        busy_s;
        logic [25:0] acc;
        string       p;

        reset = 1'b1; load_word = 1'b0; go = 1'b0; guess = '0; word_in = '0;

        // Build the directed table.
        vecs.push_back(ld(W_STAY, 5'b10000, 0));
        vecs.push_back(pr(5'd18, 5'd18, 1, 1, 5'b10001, U(18), 0, F_HIT, 0, 0));
        vecs.push_back(pr(5'd19, 5'd19, 2, 1, 5'b10011, U(18)|U(19), 0, F_HIT, 0, 0));
        vecs.push_back(pr(5'd0,  5'd0,  3, 1, 5'b10111, U(18)|U(19)|U(0), 0, F_HIT, 0, 0));
        vecs.push_back(pr(5'd24, 5'd24, 1, 1, 5'b11111, U(18)|U(19)|U(0)|U(24), 0, F_HIT, 1, 0));
        vecs.push_back(pr(5'd1,  5'd1,  1, 0, 5'b11111, U(18)|U(19)|U(0)|U(24), 0, F_HIT, 1, 0));
        vecs.push_back(ld(W_STAY, 5'b10000, 0));
        acc = '0;
        for (int k = 1; k <= 6; k++) begin
            acc |= U(k);
            vecs.push_back(pr(5'(k), 5'(k), 1, 1, 5'b10000, acc, 4'(k), F_NONE, 0, k == 6));
        end
        vecs.push_back(pr(5'd7, 5'd7, 1, 0, 5'b10000, acc, 4'd6, F_NONE, 0, 1));
        vecs.push_back(ld(W_STAY, 5'b10000, 0));
        vecs.push_back(pr(5'd1,  5'd1, 1, 1, 5'b10000, U(1), 1, F_NONE, 0, 0));
        vecs.push_back(pr(5'd1,  5'd1, 2, 1, 5'b10000, U(1), 1, F_REP, 0, 0));
        vecs.push_back(pr(5'd27, 5'd27, 1, 1, 5'b10000, U(1), 1, F_INV, 0, 0));
        vecs.push_back(pr(5'd18, 5'd1, 3, 1, 5'b10001, U(1)|U(18), 1, F_HIT, 0, 0));
        vecs.push_back(ld(W_EELL, 5'b10000, 0));
        vecs.push_back(pr(5'd4,  5'd4,  1, 1, 5'b10011, U(4), 0, F_HIT, 0, 0));
        vecs.push_back(pr(5'd11, 5'd11, 1, 1, 5'b11111, U(4)|U(11), 0, F_HIT, 1, 0));
        vecs.push_back(ld(W_NONE, 5'b11111, 1));
        vecs.push_back(pr(5'd0, 5'd0, 1, 0, 5'b11111, '0, 0, F_NONE, 1, 0));

        // Reset state.
        repeat (2) @(negedge clk);
        check_outs("reset", '0, '0, '0, F_NONE, 0, 0);
        check("reset.result_valid", 64'(result_valid), 64'(0));
        check("reset.busy", 64'(busy), 64'(0));
        reset = 1'b0;

        // Idle ignores go.
        do_press(5'd3, 5'd3, 1, n_rv, lat, busy_s);
        check("idle.rv_count", 64'(n_rv), 64'(0));
        check("idle.busy", 64'(busy_s), 64'(0));

        // Directed table.
        foreach (vecs[i]) begin
            p = $sformatf("vec%0d", i);
            if (vecs[i].is_load) begin
                do_load(vecs[i].word);
                check({p, ".result_valid"}, 64'(result_valid), 64'(0));
                check({p, ".busy"}, 64'(busy), 64'(0));
            end else begin
                do_press(vecs[i].g, vecs[i].alt, vecs[i].hold, n_rv, lat, busy_s);
                check({p, ".rv_count"}, 64'(n_rv), 64'(vecs[i].exp_rv));
                check({p, ".busy_held"}, 64'(busy_s), 64'(vecs[i].exp_rv));
                if (vecs[i].exp_rv) check({p, ".latency"}, 64'(lat), 64'(2));
            end
            check_outs(p, vecs[i].rev, vecs[i].used, vecs[i].mis, vecs[i].flg,
                       vecs[i].won, vecs[i].lost);
        end

        // Reset asserted while a guess is held: immediate all-zero, then idle.
        do_load(W_EELL);
        @(negedge clk);
        go = 1'b1; guess = 5'd4;
        @(negedge clk);
        check("rst_held.busy_before", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        check_outs("rst_held", '0, '0, '0, F_NONE, 0, 0);
        check("rst_held.busy", 64'(busy), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        go = 1'b0;
        n_rv = 0;
        repeat (6) begin
            @(negedge clk);
            if (result_valid) n_rv++;
        end
        check("rst_held.rv_count", 64'(n_rv), 64'(0));
        check("rst_held.revealed", 64'(revealed), 64'(0));

        // load_word while a guess is held: new word wins, old guess dropped.
        do_load(W_STAY);
        @(negedge clk);
        go = 1'b1; guess = 5'd18;
        @(negedge clk);
        load_word = 1'b1; word_in = W_EELL; go = 1'b0;
        @(negedge clk);
        load_word = 1'b0;
        check_outs("load_held", 5'b10000, '0, '0, F_NONE, 0, 0);
        check("load_held.busy", 64'(busy), 64'(0));
        n_rv = 0;
        repeat (6) begin
            @(negedge clk);
            if (result_valid) n_rv++;
        end
        check("load_held.rv_count", 64'(n_rv), 64'(0));
        do_press(5'd4, 5'd4, 1, n_rv, lat, busy_s);
        check("load_held.rv_after", 64'(n_rv), 64'(1));
        check_outs("load_held.after", 5'b10011, U(4), '0, F_HIT, 0, 0);

        // Randomized games against the reference model.
        for (int game = 0; game < 40; game++) begin
            logic [WW-1:0] w;
            int            len;
            len = $urandom_range(0, WORD_LEN);
            for (int i = 0; i < WORD_LEN; i++) begin
                if (i < len) w[LETTER_W*i +: LETTER_W] = 5'($urandom_range(0, 9));
                else         w[LETTER_W*i +: LETTER_W] = 5'h1F;
            end
            model_load(w);
            do_load(w);
            p = $sformatf("rnd%0d.load", game);
            check_outs(p, model_rev(), model_used(), 4'(m_mis), F_NONE, m_won, m_lost);
            for (int t = 0; t < 18; t++) begin
                logic [4:0] g;
                bit         exp_rv;
                if (($urandom_range(0, 2) == 0) && (len > 0))
                    g = w[LETTER_W*$urandom_range(0, len - 1) +: LETTER_W];
                else if ($urandom_range(0, 3) == 0)
                    g = 5'($urandom_range(0, 31));
                else
                    g = 5'($urandom_range(0, 12));
                exp_rv = model_guess(int'(g));
                do_press(g, 5'($urandom_range(0, 31)), $urandom_range(1, 4), n_rv, lat, busy_s);
                p = $sformatf("rnd%0d.g%0d", game, t);
                check({p, ".rv_count"}, 64'(n_rv), 64'(exp_rv));
                if (exp_rv) check({p, ".latency"}, 64'(lat), 64'(2));
                check_outs(p, model_rev(), model_used(), 4'(m_mis),
                           {m_hit, m_rep, m_inv}, m_won, m_lost);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hangman_guess_engine.md
Name: hangman_guess_engine

Overview:
Parametrised successor to the single-word letter-guess controller. Holds a WORD_LEN-slot target word, accepts one letter guess per go press/release, and tracks revealed positions, used letters, a miss counter and win/lose status. Sits between the switch/KEY front end (debounced go, 5-bit letter on SW) and the HEX/LEDR display datapath.

Parameters:
WORD_LEN, 5, number of letter slots; a shorter word pads unused slots with EMPTY_SLOT.
MAX_MISSES, 6, wrong guesses allowed before LOST; must be 1..15.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
load_word  in  1  one-cycle pulse; latches word_in and starts a new game
word_in  in  5*WORD_LEN  slot i at bits [5i+4:5i]; code 0..25 = A..Z, 5'h1F = empty slot
go  in  1  level, high while guess key held (already debounced, active-high)
guess  in  5  letter code 0..25; 26..31 invalid
revealed  out  WORD_LEN  bit i = slot i shown (empty slots read 1)
used_mask  out  26  bit n = letter n already guessed
misses  out  4  wrong-guess count
result_valid  out  1  one-cycle pulse after each evaluated guess
last_hit  out  1  last guess revealed at least one new slot
last_repeat  out  1  last guess was already in used_mask
last_invalid  out  1  last guess code >= 26
won  out  1  level, game won
lost  out  1  level, game lost
busy  out  1  high in S_HELD and S_EVAL

Behaviour:
- Reset: state S_IDLE; every output 0 (revealed, used_mask, misses, all flags, won, lost, busy).
- States: S_IDLE, S_WAIT_GO, S_HELD, S_EVAL, S_WON, S_LOST.
- load_word in any state (including mid-guess): synchronous, highest priority. Next cycle: word latched; revealed[i] = (slot i == 5'h1F); used_mask, misses, flags cleared; state S_WAIT_GO. If every slot is empty, state goes to S_WON instead.
- S_IDLE: ignore go; wait for load_word.
- S_WAIT_GO: go=1 -> S_HELD, latching guess into an internal register on that edge. Later changes to guess are ignored.
- S_HELD: stay while go=1; go=0 -> S_EVAL. A guess is evaluated once per press/release regardless of hold length.
- S_EVAL: exactly one cycle. hit_vec[i] = (latched guess == slot i) for each slot, computed in parallel.
  - invalid (>=26): no state change; last_invalid=1.
  - repeat (used_mask bit set): no change to misses or revealed; last_repeat=1.
  - otherwise set used_mask bit and OR hit_vec into revealed.
  - If hit_vec is nonzero, last_hit=1. If hit_vec is zero, misses increments.
  - Flags are mutually exclusive and all registered at the end of S_EVAL.
- Cycle after S_EVAL: result_valid=1 for one cycle, with the updated outputs visible. Next state:
  - S_WON if &revealed.
  - else S_LOST if misses == MAX_MISSES.
  - else S_WAIT_GO.
  - Win has priority; a miss can never produce a win, so both cannot occur together.
- S_WON / S_LOST: won or lost held high; go ignored; outputs frozen until load_word.
- Latency: go falling edge -> result_valid = 2 cycles (S_HELD->S_EVAL, S_EVAL->next).
- misses saturates at MAX_MISSES and never wraps.
- Duplicate letters in the word: a single guess reveals every matching slot.
- Reset asserted mid-game: immediate return to S_IDLE with all-zero outputs; the word is lost.

Decomposition:
- Package hangman_pkg:
  - LETTER_W=5, EMPTY_SLOT=5'h1F, ALPHABET=26.
  - Letter constants L_A..L_Z.
  - State enum for the six states.
- Sub-module letter_match (combinational, parametrised WORD_LEN): inputs guess and word, output hit_vec[WORD_LEN-1:0]. It is shared with the display datapath.

Test Plan:
- Word {S=18,T=19,A=0,Y=24,EMPTY}: load -> revealed=5'b10000, state S_WAIT_GO. Guess 18 -> revealed=5'b10001, last_hit=1, misses=0.
- Same word, guesses T, A, Y -> after Y: revealed=5'b11111, won=1. A further go press produces no result_valid.
- Six distinct wrong letters (B,C,D,E,F,G) -> misses steps 1..6; lost=1 on the 6th result_valid. A 7th press is ignored and misses stays 6.
- Guess B twice -> first press misses=1; second press last_repeat=1, misses stays 1, used_mask[1]=1.
- Guess 27 -> last_invalid=1, misses and used_mask unchanged. Change guess while go is held -> the originally latched value is evaluated.
- Word {E,E,L,L,EMPTY}: guess E -> revealed=5'b10011. Assert reset during S_HELD -> all outputs 0 next cycle, state S_IDLE.
